// File: rtl/unstacker.sv
// ---------------------------------------------------------------------------
// unstacker
//
// Purpose:
//   Breaks wide MIG read phrases (CHUNK_W bits) into a serial stream of
//   PIXEL_W-bit words, least-significant word first. It sits between the MIG
//   read-data FIFO and the pixel consumer and undoes the write-side stacker.
//   Both sides use valid/ready handshakes.
//
// Ports:
//   clk           in   1        system clock, rising edge
//   rst_n         in   1        asynchronous active-low reset
//   chunk_tvalid  in   1        input chunk valid
//   chunk_tready  out  1        a chunk can be taken this cycle
//   chunk_tdata   in   CHUNK_W  chunk; word k = bits [PIXEL_W*k +: PIXEL_W]
//   chunk_tlast   in   1        chunk ends a frame/burst
//   pixel_tvalid  out  1        output word valid
//   pixel_tready  in   1        downstream takes the word this cycle
//   pixel_tdata   out  PIXEL_W  output word
//   pixel_tlast   out  1        final word of a chunk that carried tlast
//   busy          out  1        a chunk is held and not fully drained
// ---------------------------------------------------------------------------
module unstacker #(
    parameter int CHUNK_W = 128,
    parameter int PIXEL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               chunk_tvalid,
    output logic               chunk_tready,
    input  logic [CHUNK_W-1:0] chunk_tdata,
    input  logic               chunk_tlast,
    output logic               pixel_tvalid,
    input  logic               pixel_tready,
    output logic [PIXEL_W-1:0] pixel_tdata,
    output logic               pixel_tlast,
    output logic               busy
);

    localparam int NWORDS = CHUNK_W / PIXEL_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    // A partial trailing word would be silently dropped, so refuse to build.
    if (CHUNK_W % PIXEL_W != 0) begin : g_width_check
        $error("unstacker: CHUNK_W must be a multiple of PIXEL_W");
    end

    logic [CHUNK_W-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               have_q, have_d;
    logic               last_q, last_d;

    logic               final_word;
    logic               acc_in;
    logic               acc_out;

    // Outputs are taken straight from the state registers, so pixel_tvalid
    // never depends on pixel_tready.
    assign pixel_tvalid = have_q;
    assign pixel_tdata  = sr_q[PIXEL_W-1:0];
    assign pixel_tlast  = have_q & last_q & final_word;
    assign busy         = have_q;

    // The only combinational path through the block: when the last word of
    // the held chunk is leaving, a new chunk may load in the same cycle so
    // the output stream has no bubble between chunks.
    always_comb begin
        final_word   = (idx_q == LAST_IDX);
        chunk_tready = !have_q | (pixel_tready & final_word);
        acc_in       = chunk_tvalid & chunk_tready;
        acc_out      = have_q & pixel_tready;
    end

    // Next-state logic. A load takes priority over draining the final word;
    // otherwise an accepted word shifts the register down by one word (zero
    // fill) until the final word, which empties the holder.
    always_comb begin
        sr_d   = sr_q;
        idx_d  = idx_q;
        have_d = have_q;
        last_d = last_q;
        if (acc_in) begin
            sr_d   = chunk_tdata;
            idx_d  = '0;
            have_d = 1'b1;
            last_d = chunk_tlast;
        end else if (acc_out) begin
            if (final_word) begin
                have_d = 1'b0;
                idx_d  = '0;
            end else begin
                sr_d  = sr_q >> PIXEL_W;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // State registers; reset discards any partially drained chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            idx_q  <= '0;
            have_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            idx_q  <= idx_d;
            have_q <= have_d;
            last_q <= last_d;
        end
    end

endmodule
